// File: rtl/song_reader.sv
// Song ROM sequencer: fetches {note, duration} entries one at a time and hands each one
// to the note player. It waits for note_done between entries and handles pause/resume through play.
module song_reader #(
   parameter int IDX_W  = 5,
   parameter int SONG_W = 2,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      play,
   input  logic [SONG_W-1:0]         song,
   input  logic                      note_done,
   output logic [SONG_W+IDX_W-1:0]   rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]   rom_data,
   output logic [NOTE_W-1:0]         note,
   output logic [DUR_W-1:0]          duration,
   output logic                      new_note,
   output logic                      song_done
);

   typedef enum logic [2:0] {
      IDLE, FETCH, LATCH, WAIT_NOTE, PAUSED, REISSUE
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic [SONG_W-1:0]   song_q, song_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [DUR_W-1:0]    duration_q, duration_d;
   logic                new_note_q, new_note_d;
   logic                song_done_q, song_done_d;
   logic                armed_q, armed_d;

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      song_d      = song_q;
      note_d      = note_q;
      duration_d  = duration_q;
      new_note_d  = 1'b0;
      song_done_d = 1'b0;
      armed_d     = armed_q;
      case (state_q)
         IDLE: begin
            if (play && armed_q) begin
               song_d  = song;
               index_d = '0;
               state_d = FETCH;
            end
            // Play must drop after a finished song before another can start.
            if (!play) armed_d = 1'b1;
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            if (rom_data[DUR_W-1:0] == '0) begin
               song_done_d = 1'b1;
               armed_d     = 1'b0;
               state_d     = IDLE;
            end else begin
               note_d     = rom_data[NOTE_W+DUR_W-1:DUR_W];
               duration_d = rom_data[DUR_W-1:0];
               new_note_d = 1'b1;
               state_d    = WAIT_NOTE;
            end
         end
         WAIT_NOTE: begin
            if (note_done && (&index_q)) begin
               song_done_d = 1'b1;
               armed_d     = 1'b0;
               state_d     = IDLE;
            end else if (note_done) begin
               index_d = index_q + 1'b1;
               state_d = FETCH;
            end else if (!play) begin
               state_d = PAUSED;
            end
         end
         // note_done is ignored here since the player is held in reset while paused.
         PAUSED: if (play) state_d = REISSUE;
         REISSUE: begin
            new_note_d = 1'b1;
            state_d    = WAIT_NOTE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         index_q     <= '0;
         song_q      <= '0;
         note_q      <= '0;
         duration_q  <= '0;
         new_note_q  <= 1'b0;
         song_done_q <= 1'b0;
         armed_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         song_q      <= song_d;
         note_q      <= note_d;
         duration_q  <= duration_d;
         new_note_q  <= new_note_d;
         song_done_q <= song_done_d;
         armed_q     <= armed_d;
      end
   end

   assign rom_addr  = {song_q, index_q};
   assign note      = note_q;
   assign duration  = duration_q;
   assign new_note  = new_note_q;
   assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: stimulus queues expected note/song_done events
// and a forked monitor pops and compares them whenever the DUT strobes.
module tb_song_reader;

   logic        clk = 1'b0;
   logic        reset, play, note_done;
   logic [1:0]  song;
   logic [6:0]  rom_addr;
   logic [11:0] rom_data;
   logic [5:0]  note, duration;
   logic        new_note, song_done;

   logic [11:0] rom [128];

   typedef struct {
      logic       sd;
      logic [5:0] note;
      logic [5:0] dur;
      logic [6:0] addr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   nn_cnt = 0;
   int   sd_cnt = 0;

   song_reader dut (
      .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
      .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .duration(duration),
      .new_note(new_note), .song_done(song_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not end, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic push(input logic sd, input int n, input int d, input int a);
      exp_t e;
      e.sd = sd; e.note = 6'(n); e.dur = 6'(d); e.addr = 7'(a);
      q.push_back(e);
   endtask

   task automatic pulse_done();
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
   endtask

   task automatic wait_nn(input int target, input string nm);
      int n = 0;
      while (nn_cnt < target && n < 100) begin tick(); n++; end
      chk(nm, nn_cnt, target);
   endtask

   task automatic wait_sd(input int target, input string nm);
      int n = 0;
      while (sd_cnt < target && n < 100) begin tick(); n++; end
      chk(nm, sd_cnt, target);
   endtask

   task automatic monitor();
      logic prev_nn = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (new_note && song_done) begin
            checks++; errors++;
            $display("FAIL strobe_overlap: new_note=1 song_done=1, required not both");
         end
         if (new_note && prev_nn) begin
            checks++; errors++;
            $display("FAIL new_note_twice: consecutive new_note, required single cycle");
         end
         prev_nn = new_note;
         if (new_note || song_done) begin
            if (new_note) nn_cnt++;
            if (song_done) sd_cnt++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: new_note=%0d song_done=%0d addr=%0h, required none",
                        new_note, song_done, rom_addr);
            end else begin
               e = q.pop_front();
               if (song_done != e.sd || new_note == e.sd || note != e.note ||
                   duration != e.dur || rom_addr != e.addr) begin
                  errors++;
                  $display("FAIL event: sd=%0d note=%0d dur=%0d addr=%0h, required sd=%0d note=%0d dur=%0d addr=%0h",
                           song_done, note, duration, rom_addr, e.sd, e.note, e.dur, e.addr);
               end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = '0;
      rom[64] = {6'd17, 6'd8};
      rom[65] = {6'd5, 6'd12};
      rom[66] = {6'd9, 6'd0};
      for (int i = 0; i < 32; i++) rom[32 + i] = {6'(i + 1), 6'(i + 2)};
      for (int i = 0; i < 32; i++) rom[96 + i] = {6'(40 + (i % 20)), 6'(10 + i)};
      note_done = 1'b0;
      reset = 1'b1; play = 1'b1; song = 2'd2;
      fork monitor(); join_none

      // Reset state
      tick();
      chk("rst_note", note, 0);
      chk("rst_duration", duration, 0);
      chk("rst_new_note", new_note, 0);
      chk("rst_song_done", song_done, 0);
      chk("rst_rom_addr", rom_addr, 0);

      // First note latency and address
      reset = 1'b0;
      push(1'b0, 17, 8, 'h40);
      tick();
      chk("addr_edge1", rom_addr, 'h40);
      chk("nn_edge1", new_note, 0);
      tick();
      tick();
      chk("nn_edge3", new_note, 1);
      chk("note_edge3", note, 17);
      wait_nn(1, "wait_first_note");

      // Second note, then end-of-song marker
      push(1'b0, 5, 12, 'h41);
      pulse_done();
      wait_nn(2, "wait_second_note");
      push(1'b1, 5, 12, 'h42);
      pulse_done();
      wait_sd(1, "wait_marker_done");

      // No auto-restart while play stays high
      repeat (20) tick();
      chk("no_restart_nn", nn_cnt, 2);
      chk("no_restart_sd", sd_cnt, 1);
      chk("hold_note", note, 5);
      chk("hold_duration", duration, 12);
      play = 1'b0;
      tick();
      push(1'b0, 17, 8, 'h40);
      play = 1'b1;
      wait_nn(3, "wait_rearm_note");

      // Pause with note_done injected while paused
      play = 1'b0;
      for (int i = 0; i < 10; i++) begin
         note_done = (i == 3 || i == 6);
         tick();
      end
      note_done = 1'b0;
      chk("pause_nn", nn_cnt, 3);
      push(1'b0, 17, 8, 'h40);
      play = 1'b1;
      wait_nn(4, "wait_reissue");

      // Full 32-entry song 1
      reset = 1'b1; play = 1'b0;
      tick();
      reset = 1'b0; song = 2'd1; play = 1'b1;
      for (int i = 0; i < 32; i++) begin
         push(1'b0, i + 1, i + 2, 'h20 + i);
         wait_nn(5 + i, "wait_song1_note");
         if (i == 31) push(1'b1, 32, 33, 'h3F);
         pulse_done();
      end
      wait_sd(2, "wait_song1_done");
      chk("song1_notes", nn_cnt, 36);

      // Reset mid-song at index 7 of song 3
      play = 1'b0;
      tick();
      song = 2'd3; play = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push(1'b0, 40 + i, 10 + i, 'h60 + i);
         wait_nn(37 + i, "wait_song3_note");
         if (i < 7) pulse_done();
      end
      reset = 1'b1;
      tick();
      chk("midrst_note", note, 0);
      chk("midrst_duration", duration, 0);
      chk("midrst_new_note", new_note, 0);
      chk("midrst_rom_addr", rom_addr, 0);
      reset = 1'b0;
      push(1'b0, 40, 10, 'h60);
      wait_nn(45, "wait_restart_note");

      reset = 1'b1;
      tick();
      tick();
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
